vga_frame_capture: RTL and testbench

- Receive-side counterpart to the VGA pixel source.
- Samples an incoming 12-bit RGB + HSYNC/VSYNC stream on the pixel clock and locates a fixed H_ACTIVE x V_ACTIVE window relative to the sync edges.
- Emits a linear write stream (address, data, enable) into a frame RAM of the same 600x500 layout the display path reads from.
- Armed by software; single-shot or continuous capture.

---
 rtl/vga_frame_capture.sv | 187 ++++++++++++++++++
 tb/tb_vga_frame_capture.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_capture.sv
// Purpose: capture a fixed active window from a sampled VGA stream as a linear frame-RAM write stream.
// Latency: RGB on the pins at edge N appears on wr_data (with wr_en and wr_addr) at edge N+2.
// Backpressure: none; the frame RAM must accept one write per pixel clock.
// Optional feature: define VGA_CAPTURE_MEASURE_EN to add h_total/v_total line and frame measurement outputs.
module vga_frame_capture #(
    parameter int   H_ACTIVE = 600,
    parameter int   V_ACTIVE = 500,
    parameter int   H_START  = 184,
    parameter int   V_START  = 29,
    parameter logic SYNC_POL = 1'b1,
    parameter int   ADDR_W   = 19
) (
    input  logic              pclk,
    input  logic              reset_n,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic [3:0]        red_in,
    input  logic [3:0]        grn_in,
    input  logic [3:0]        blu_in,
    input  logic              arm,
    input  logic              continuous,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_short
`ifdef VGA_CAPTURE_MEASURE_EN
    ,
    output logic [11:0]       h_total,
    output logic [11:0]       v_total
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Window bounds widened to 12 bits so START+ACTIVE cannot overflow the 11-bit counters.
    localparam logic [11:0]       H_LO      = 12'(H_START);
    localparam logic [11:0]       H_HI      = 12'(H_START + H_ACTIVE);
    localparam logic [11:0]       V_LO      = 12'(V_START);
    localparam logic [11:0]       V_HI      = 12'(V_START + V_ACTIVE);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [10:0]       CNT_MAX   = 11'h7FF;

    state_t state;
    state_t state_nxt;

    logic        hs1;
    logic        vs1;
    logic        hs2;
    logic        vs2;
    logic [11:0] rgb1;
    logic [11:0] rgb2;
    logic [10:0] pix_cnt;
    logic [10:0] line_cnt;
    logic [ADDR_W-1:0] addr_cnt;

    logic hs_lead;
    logic vs_lead;
    logic in_win;
    logic wr_fire;
    logic last_fire;
    logic done_c;

    // Leading edges: stage-1 copy at the active level while stage-2 copy is not.
    always_comb begin
        hs_lead = (hs1 == SYNC_POL) && (hs2 != SYNC_POL);
        vs_lead = (vs1 == SYNC_POL) && (vs2 != SYNC_POL);
    end

    // Window decode on the counters, which describe the pixel held in rgb2.
    always_comb begin
        in_win    = ({1'b0, line_cnt} >= V_LO) && ({1'b0, line_cnt} < V_HI) &&
                    ({1'b0, pix_cnt}  >= H_LO) && ({1'b0, pix_cnt}  < H_HI);
        wr_fire   = (state == S_CAPTURE) && in_win;
        last_fire = wr_fire && (addr_cnt == LAST_ADDR);
    end

    // State register.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a completed frame takes priority over a concurrent VSYNC restart.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (arm)       state_nxt = S_WAIT;
            S_WAIT:    if (vs_lead)   state_nxt = S_CAPTURE;
            S_CAPTURE: if (last_fire) state_nxt = S_DONE;
            S_DONE:    state_nxt = continuous ? S_WAIT : S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy   = (state == S_WAIT) || (state == S_CAPTURE);
        done_c = (state == S_DONE);
    end

    // Input pipeline, sync counters, address counter and registered write port.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            hs1         <= 1'b0;
            vs1         <= 1'b0;
            hs2         <= 1'b0;
            vs2         <= 1'b0;
            rgb1        <= '0;
            rgb2        <= '0;
            pix_cnt     <= '0;
            line_cnt    <= '0;
            addr_cnt    <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_done  <= 1'b0;
            frame_short <= 1'b0;
        end else begin
            hs1  <= hsync_in;
            vs1  <= vsync_in;
            rgb1 <= {red_in, grn_in, blu_in};
            hs2  <= hs1;
            vs2  <= vs1;
            rgb2 <= rgb1;

            if (hs_lead) begin
                pix_cnt <= '0;
            end else if (pix_cnt != CNT_MAX) begin
                pix_cnt <= pix_cnt + 11'd1;
            end

            if (vs_lead) begin
                line_cnt <= '0;
            end else if (hs_lead && (line_cnt != CNT_MAX)) begin
                line_cnt <= line_cnt + 11'd1;
            end

            wr_en <= wr_fire;
            if (wr_fire) begin
                wr_addr <= addr_cnt;
                wr_data <= rgb2;
            end

            if ((state == S_WAIT) && vs_lead) begin
                addr_cnt <= '0;
            end else if (state == S_CAPTURE) begin
                if (vs_lead && !last_fire) begin
                    addr_cnt <= '0;
                end else if (wr_fire) begin
                    addr_cnt <= addr_cnt + ADDR_ONE;
                end
            end

            frame_short <= (state == S_CAPTURE) && vs_lead && !last_fire;
            frame_done  <= done_c;
        end
    end

`ifdef VGA_CAPTURE_MEASURE_EN
    // Line length and frame height latched from the counters just before they clear.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            h_total <= '0;
            v_total <= '0;
        end else begin
            if (hs_lead) begin
                h_total <= {1'b0, pix_cnt} + 12'd1;
            end
            if (vs_lead) begin
                v_total <= {1'b0, line_cnt} + 12'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_frame_capture.sv
// Purpose: randomized frame-capture bench with a pixel-level reference model and a write scoreboard.
// Latency: expected writes are tagged with the cycle they must appear (drive edge + 2).
// Backpressure: none; the monitor consumes every write the DUT issues.
module tb_vga_frame_capture;

    localparam int   HA   = 8;
    localparam int   VA   = 4;
    localparam int   HS   = 5;
    localparam int   VS   = 3;
    localparam int   AW   = 19;
    localparam logic POL  = 1'b1;
    localparam int   HT   = 20;
    localparam int   HSW  = 3;
    localparam int   VT   = 10;
    localparam int   VSW  = 2;
    localparam int   NPIX = HA * VA;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_CAP  = 2;

    logic          pclk = 1'b0;
    logic          reset_n = 1'b0;
    logic          hsync_in = 1'b0;
    logic          vsync_in = 1'b0;
    logic [3:0]    red_in = '0;
    logic [3:0]    grn_in = '0;
    logic [3:0]    blu_in = '0;
    logic          arm = 1'b0;
    logic          continuous = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;
    logic          busy;
    logic          frame_done;
    logic          frame_short;
`ifdef VGA_CAPTURE_MEASURE_EN
    logic [11:0]   h_total;
    logic [11:0]   v_total;
`endif

    vga_frame_capture #(
        .H_ACTIVE (HA),
        .V_ACTIVE (VA),
        .H_START  (HS),
        .V_START  (VS),
        .SYNC_POL (POL),
        .ADDR_W   (AW)
    ) dut (
        .pclk        (pclk),
        .reset_n     (reset_n),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .red_in      (red_in),
        .grn_in      (grn_in),
        .blu_in      (blu_in),
        .arm         (arm),
        .continuous  (continuous),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_short (frame_short)
`ifdef VGA_CAPTURE_MEASURE_EN
        ,
        .h_total     (h_total),
        .v_total     (v_total)
`endif
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        int          addr;
        logic [11:0] data;
        int          when;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   exp_done = 0;
    int   got_done = 0;
    int   exp_short = 0;
    int   got_short = 0;
    int   last_addr = -1;
    int   mst = M_IDLE;
    int   maddr = 0;

    task automatic check(string name, int actual, int required);
        total++;
        if (actual != required) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, required, cyc);
        end
    endtask

    // Scoreboard monitor: every write must match the head of the expected queue.
    always @(negedge pclk) begin
        exp_t e;
        if (reset_n) begin
            if (wr_en) begin
                check("write_was_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", int'(wr_addr), e.addr);
                    check("wr_data", int'(wr_data), int'(e.data));
                    check("wr_latency", cyc, e.when);
                    last_addr = int'(wr_addr);
                end
            end
            if (frame_done) begin
                got_done++;
                check("done_after_last_addr", last_addr, NPIX - 1);
            end
            if (frame_short) begin
                got_short++;
            end
        end
    end

    // Reference model works per pixel in frame coordinates, then the pixel is clocked in.
    task automatic drive_pix(int l, int p, logic a);
        logic [11:0] rgb;
        exp_t        e;
        rgb = 12'($urandom);
        hsync_in = (p < HSW) ? POL : ~POL;
        vsync_in = (l < VSW) ? POL : ~POL;
        {red_in, grn_in, blu_in} = rgb;
        arm = a;
        if (a && mst == M_IDLE) mst = M_WAIT;
        if (l == 0 && p == 0) begin
            if (mst == M_WAIT) begin
                mst = M_CAP;
                maddr = 0;
            end else if (mst == M_CAP) begin
                exp_short++;
                maddr = 0;
            end
        end
        if (mst == M_CAP && l >= VS && l < VS + VA && p >= HS && p < HS + HA) begin
            e.addr = maddr;
            e.data = rgb;
            e.when = cyc + 3;
            exp_q.push_back(e);
            maddr++;
            if (maddr == NPIX) begin
                exp_done++;
                mst = continuous ? M_WAIT : M_IDLE;
            end
        end
        @(posedge pclk);
        #1;
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", int'(wr_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_frame_short", int'(frame_short), 0);
        mst = M_IDLE;
        exp_q.delete();
        repeat (3) @(posedge pclk);
        #2 reset_n = 1'b1;
    endtask

    task automatic run_frame(int nlines, logic a, logic c, int rst_line);
        for (int l = 0; l < nlines; l++) begin
            for (int p = 0; p < HT; p++) begin
                if (l == rst_line && p == 4) do_reset();
                if (l == 2 && p == 10) check("busy_state", int'(busy), int'(mst != M_IDLE));
                if (l == 8 && p == 10) continuous = c;
                drive_pix(l, p, (l == 8 && p == 10) ? a : 1'b0);
            end
        end
    endtask

    // Directed opening: single-shot, continuous, abort, reset mid-capture, idle frames.
    int   t_arm[9]  = '{1, 0, 1, 0, 1, 0, 1, 0, 0};
    int   t_cont[9] = '{0, 0, 1, 1, 1, 0, 0, 0, 0};
    int   t_cut[9]  = '{VT, VT, VT, VT, 5, VT, VT, VT, VT};
    int   t_rst[9]  = '{-1, -1, -1, -1, -1, -1, 4, -1, -1};

    initial begin
        int   a;
        int   c;
        int   cut;
        int   rl;
        int   guard;
        reset_n = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        check("init_wr_en", int'(wr_en), 0);
        check("init_wr_addr", int'(wr_addr), 0);
        check("init_busy", int'(busy), 0);
        check("init_frame_done", int'(frame_done), 0);
`ifdef VGA_CAPTURE_MEASURE_EN
        check("init_h_total", int'(h_total), 0);
        check("init_v_total", int'(v_total), 0);
`endif
        reset_n = 1'b1;
        @(posedge pclk);
        #1;

        for (int f = 0; f < 30; f++) begin
            if (f < 9) begin
                a = t_arm[f];
                c = t_cont[f];
                cut = t_cut[f];
                rl = t_rst[f];
            end else begin
                a = int'($urandom_range(1, 0));
                c = int'($urandom_range(1, 0));
                cut = ($urandom_range(4, 0) == 0) ? int'($urandom_range(VS + VA - 1, VS + 1)) : VT;
                rl = ($urandom_range(7, 0) == 0) ? VS + 1 : -1;
            end
            run_frame(cut, a[0], c[0], rl);
        end

        // One clean full frame followed by the start of the next, so v_total sees a full frame.
        run_frame(VT, 1'b0, continuous, -1);
        run_frame(2, 1'b0, continuous, -1);

        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(posedge pclk);
            #1;
            guard++;
        end
        repeat (4) @(posedge pclk);
        #1;

        check("queue_drained", exp_q.size(), 0);
        check("frame_done_count", got_done, exp_done);
        check("frame_short_count", got_short, exp_short);
        check("busy_end", int'(busy), int'(mst != M_IDLE));
`ifdef VGA_CAPTURE_MEASURE_EN
        check("h_total", int'(h_total), HT);
        check("v_total", int'(v_total), VT);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
